afifo_wr_arbiter: RTL

//  Round-robin, packet-locked arbiter that shares the single write port of
//  one aFIFO (wpush/wdata/wfull) among NREQ write-side requesters.

---
 rtl/afifo_wr_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one aFIFO write port among NREQ requesters.
// Each pushed word carries {requester id, last, data} so the read side can demultiplex.
module afifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int IDW       = $clog2(NREQ),
    parameter int MAX_BURST = 16
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 wfull,
    output logic                 wpush,
    output logic [IDW+DW:0]      wdata,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 err_long
);

    localparam int              CNTW     = $clog2(MAX_BURST);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAX_BURST - 1);
    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);
    localparam logic [IDW:0]    NREQ_W   = (IDW + 1)'(NREQ);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  grant_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [CNTW-1:0] beat_cnt_q;
    logic [CNTW-1:0] beat_cnt_d;
    logic            err_long_q;

    logic            sel_valid;
    logic            sel_last;
    logic [DW-1:0]   sel_data;

    logic            pick_found;
    logic [IDW-1:0]  pick_id;
    logic [IDW:0]    scan_sum;
    logic [IDW-1:0]  scan_id;

    logic            burst_end;
    logic [IDW-1:0]  rr_next;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DW +: DW];
            end
        end
    end

    // Scan rr_ptr, rr_ptr+1, ... modulo NREQ and keep the first valid requester.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_sum   = '0;
        scan_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
            if (scan_sum >= NREQ_W) begin
                scan_sum = scan_sum - NREQ_W;
            end
            scan_id = scan_sum[IDW-1:0];
            if (!pick_found && req_valid[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == LOCK && !wfull) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign wpush      = (state_q == LOCK) & sel_valid & ~wfull;
    assign wdata      = {grant_q, sel_last, sel_data};
    assign busy       = (state_q == LOCK);
    assign grant_id   = grant_q;
    assign err_long   = err_long_q;

    assign beat_cnt_d = beat_cnt_q + 1'b1;
    assign burst_end  = sel_last | (beat_cnt_q == LAST_CNT);
    assign rr_next    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_long_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q    <= pick_id;
                        beat_cnt_q <= '0;
                        state_q    <= LOCK;
                    end
                end
                LOCK: begin
                    // Without an accepted beat the grant is simply held; bubbles and stalls are legal.
                    if (wpush) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (burst_end) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= rr_next;
                            if (!sel_last) begin
                                err_long_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
